// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, line constants and a parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  localparam int   UART_CLKS_PER_BIT_DEFAULT = 868;
  localparam logic UART_IDLE_LEVEL           = 1'b1;

  // Parity over the low data_bits of data; odd=1 inverts even parity.
  function automatic logic data_parity(input logic [7:0] data, input int data_bits, input logic odd);
    logic p;
    p = odd;
    for (int i = 0; i < 8; i++) begin
      if (i < data_bits) p = p ^ data[i];
    end
    return p;
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module uart_baud_counter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_end
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_clks
      $error("uart_baud_counter: CLKS_PER_BIT must be >= 2");
    end
  endgenerate

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear || bit_end) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  assign bit_end = (count == LAST);

endmodule

// File: rtl/uart_tx_shifter.sv
// UART transmit serializer: frames the held data byte onto tx_serial with its own baud timing.
module uart_tx_shifter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       tx_serial,
  output logic       tx_done
);

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_clks
      $error("uart_tx_shifter: CLKS_PER_BIT must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data
      $error("uart_tx_shifter: DATA_BITS must be 5..8");
    end
    if (PARITY_EN != 0 && PARITY_EN != 1) begin : g_bad_pen
      $error("uart_tx_shifter: PARITY_EN must be 0 or 1");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_podd
      $error("uart_tx_shifter: PARITY_ODD must be 0 or 1");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
      $error("uart_tx_shifter: STOP_BITS must be 1 or 2");
    end
  endgenerate

  localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic       ODD       = (PARITY_ODD != 0);

  tx_state_t  state;
  logic [2:0] bit_cnt;
  logic       stop_cnt;
  logic [7:0] shift_reg;
  logic       parity_bit;
  logic       bit_end;
  logic       baud_clear;

  // Holding the counter at zero while idle makes the start bit a full period.
  assign baud_clear = (state == TX_IDLE);

  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .reset  (reset),
    .clear  (baud_clear),
    .bit_end(bit_end)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= TX_IDLE;
      tx_serial  <= UART_IDLE_LEVEL;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        TX_IDLE: begin
          tx_serial <= UART_IDLE_LEVEL;
          tx_busy   <= 1'b0;
          if (tx_start) begin
            state     <= TX_START;
            tx_busy   <= 1'b1;
            tx_serial <= 1'b0;
          end
        end
        TX_START: begin
          // The data register is stable by now; capture it and its parity together.
          if (bit_end) begin
            state      <= TX_DATA;
            shift_reg  <= tx_data;
            parity_bit <= data_parity(tx_data, DATA_BITS, ODD);
            tx_serial  <= tx_data[0];
            bit_cnt    <= '0;
          end
        end
        TX_DATA: begin
          if (bit_end) begin
            if (bit_cnt == LAST_DATA) begin
              if (PARITY_EN != 0) begin
                state     <= TX_PARITY;
                tx_serial <= parity_bit;
              end else begin
                state     <= TX_STOP;
                tx_serial <= UART_IDLE_LEVEL;
                stop_cnt  <= 1'b0;
              end
            end else begin
              bit_cnt   <= bit_cnt + 3'd1;
              shift_reg <= shift_reg >> 1;
              tx_serial <= shift_reg[1];
            end
          end
        end
        TX_PARITY: begin
          if (bit_end) begin
            state     <= TX_STOP;
            tx_serial <= UART_IDLE_LEVEL;
            stop_cnt  <= 1'b0;
          end
        end
        TX_STOP: begin
          if (bit_end) begin
            if (stop_cnt == LAST_STOP) begin
              state   <= TX_IDLE;
              tx_busy <= 1'b0;
              tx_done <= 1'b1;
            end else begin
              stop_cnt <= stop_cnt + 1'b1;
            end
          end
        end
        default: begin
          state     <= TX_IDLE;
          tx_serial <= UART_IDLE_LEVEL;
          tx_busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_shifter.sv
// Scoreboard bench for uart_tx_shifter: three configurations driven in parallel, waveforms checked per cycle.
module tb_uart_tx_shifter;

  localparam int CPB = 4;

  typedef struct {
    int         start;
    logic [7:0] data;
  } frame_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tx_start  [3];
  logic [7:0] tx_data   [3];
  logic       tx_busy   [3];
  logic       tx_serial [3];
  logic       tx_done   [3];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  frame_t     exp_q [3][$];
  int         free_at   [3];
  int         last_acc  [3];
  logic [7:0] want_data [3];
  bit         want_start[3];
  bit         mon_act   [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // inst0: 8N1, inst1: 8E1, inst2: 7O2
  uart_tx_shifter #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut0 (
    .clk(clk), .reset(reset), .tx_start(tx_start[0]), .tx_data(tx_data[0]),
    .tx_busy(tx_busy[0]), .tx_serial(tx_serial[0]), .tx_done(tx_done[0]));
  uart_tx_shifter #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_dut1 (
    .clk(clk), .reset(reset), .tx_start(tx_start[1]), .tx_data(tx_data[1]),
    .tx_busy(tx_busy[1]), .tx_serial(tx_serial[1]), .tx_done(tx_done[1]));
  uart_tx_shifter #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u_dut2 (
    .clk(clk), .reset(reset), .tx_start(tx_start[2]), .tx_data(tx_data[2]),
    .tx_busy(tx_busy[2]), .tx_serial(tx_serial[2]), .tx_done(tx_done[2]));

  function automatic int cfg_db(int i); return (i == 2) ? 7 : 8; endfunction
  function automatic int cfg_pe(int i); return (i == 0) ? 0 : 1; endfunction
  function automatic int cfg_po(int i); return (i == 2) ? 1 : 0; endfunction
  function automatic int cfg_sb(int i); return (i == 2) ? 2 : 1; endfunction
  function automatic int flen(int i);
    return (1 + cfg_db(i) + cfg_pe(i) + cfg_sb(i)) * CPB + 1;
  endfunction

  function automatic logic exp_parity(int i, logic [7:0] d);
    int ones = 0;
    for (int j = 0; j < cfg_db(i); j++) ones += int'(d[j]);
    return logic'((ones % 2) != cfg_po(i));
  endfunction

  // Expected {busy, serial, done} at cycle t for frame f accepted at cycle f.start.
  function automatic logic [2:0] expect_out(int i, frame_t f, int t);
    int   r, nb, k;
    logic b;
    nb = 1 + cfg_db(i) + cfg_pe(i) + cfg_sb(i);
    r  = t - f.start;
    if (r == nb * CPB + 1) return 3'b011;
    if (r < 1 || r > nb * CPB) return 3'b010;
    k = (r - 1) / CPB;
    if (k == 0) b = 1'b0;
    else if (k <= cfg_db(i)) b = f.data[k-1];
    else if (cfg_pe(i) != 0 && k == cfg_db(i) + 1) b = exp_parity(i, f.data);
    else b = 1'b1;
    return {1'b1, b, 1'b0};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: apply requested inputs and let the model decide which starts are accepted.
  task automatic step();
    frame_t f;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      if (cyc > last_acc[i] + CPB) tx_data[i] = want_data[i];
      tx_start[i] = want_start[i];
      if (want_start[i] && !reset && cyc >= free_at[i]) begin
        f.start = cyc;
        f.data  = tx_data[i];
        exp_q[i].push_back(f);
        last_acc[i] = cyc;
        free_at[i]  = cyc + flen(i);
      end
    end
  endtask

  task automatic flush_model();
    for (int i = 0; i < 3; i++) begin
      exp_q[i].delete();
      free_at[i]  = 0;
      last_acc[i] = -1000;
    end
  endtask

  // Monitor: pops an expected frame when busy rises, then compares every cycle.
  initial begin
    frame_t     cur [3];
    logic [2:0] exp_v, act_v;
    for (int i = 0; i < 3; i++) mon_act[i] = 1'b0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        act_v = {tx_busy[i], tx_serial[i], tx_done[i]};
        if (reset) begin
          mon_act[i] = 1'b0;
        end else if (!mon_act[i] && tx_busy[i] === 1'b1) begin
          if (exp_q[i].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame inst%0d cycle %0d: got busy 1 expected 0", i, cyc);
          end else begin
            cur[i]     = exp_q[i].pop_front();
            mon_act[i] = 1'b1;
          end
        end
        exp_v = mon_act[i] ? expect_out(i, cur[i], cyc) : 3'b010;
        checks++;
        if (act_v !== exp_v) begin
          errors++;
          $display("FAIL wave inst%0d cycle %0d: got busy/serial/done %b expected %b", i, cyc, act_v, exp_v);
        end
        if (mon_act[i] && cyc - cur[i].start >= flen(i)) begin
          $display("frame inst%0d data %02h accepted at %0d completed at %0d", i, cur[i].data, cur[i].start, cyc);
          mon_act[i] = 1'b0;
        end
      end
    end
  end

  initial begin
    int c, first, second, ndone;
    for (int i = 0; i < 3; i++) begin
      tx_start[i]   = 1'b0;
      tx_data[i]    = 8'h00;
      want_start[i] = 1'b0;
      want_data[i]  = 8'h00;
    end
    flush_model();

    // Reset state and quiet line afterwards
    reset = 1'b1;
    repeat (3) step();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_busy%0d", i), 32'(tx_busy[i]), 0);
      check($sformatf("rst_serial%0d", i), 32'(tx_serial[i]), 1);
      check($sformatf("rst_done%0d", i), 32'(tx_done[i]), 0);
    end
    step();
    #1 reset = 1'b0;
    repeat (10) step();
    #1 reset = 1'b1;
    #1 check("idle_rst_serial", 32'(tx_serial[0]), 1);
    step();
    #1 reset = 1'b0;
    repeat (5) step();
    check("post_rst_serial", 32'(tx_serial[0]), 1);

    // 8N1 0xA5 with latency checks
    want_data[0] = 8'hA5; want_start[0] = 1'b1;
    step();
    c = cyc; want_start[0] = 1'b0;
    step();
    check("a5_busy_rise", 32'(tx_busy[0]), 1);
    check("a5_start_bit", 32'(tx_serial[0]), 0);
    first = -1;
    for (int k = 0; k < 60; k++) begin
      step();
      if (tx_done[0] && first < 0) first = cyc - c;
    end
    check("a5_done_latency", first, 41);

    // Parity: 0x07 even -> 1, 0x07 odd -> 0, 0x00 even -> 0
    want_data[1] = 8'h07; want_start[1] = 1'b1;
    want_data[2] = 8'h07; want_start[2] = 1'b1;
    step();
    c = cyc; want_start[1] = 1'b0; want_start[2] = 1'b0;
    first = -1;
    for (int k = 0; k < 55; k++) begin
      step();
      if (cyc == c + 34) check("par_odd_07", 32'(tx_serial[2]), 0);
      if (cyc == c + 38) check("par_even_07", 32'(tx_serial[1]), 1);
      if (tx_done[1] && first < 0) first = cyc - c;
    end
    check("par_frame_len", first, 45);
    want_data[1] = 8'h00; want_start[1] = 1'b1;
    step();
    c = cyc; want_start[1] = 1'b0;
    for (int k = 0; k < 50; k++) begin
      step();
      if (cyc == c + 38) check("par_even_00", 32'(tx_serial[1]), 0);
    end

    // Start pulse during DATA and data change after START are ignored
    want_data[0] = 8'h3A; want_start[0] = 1'b1;
    step();
    c = cyc; want_start[0] = 1'b0;
    repeat (12) step();
    want_start[0] = 1'b1; want_data[0] = 8'hFF;
    step();
    want_start[0] = 1'b0; want_data[0] = 8'h5C;
    first = -1; ndone = 0;
    for (int k = 0; k < 60; k++) begin
      step();
      if (tx_done[0]) begin
        ndone++;
        if (first < 0) first = cyc - c;
      end
    end
    check("ignore_done_count", ndone, 1);
    check("ignore_done_latency", first, 41);

    // Asynchronous reset during data bit 3
    want_data[0] = 8'h55; want_start[0] = 1'b1;
    step();
    c = cyc; want_start[0] = 1'b0;
    while (cyc < c + 18) step();
    check("mid_frame_busy", 32'(tx_busy[0]), 1);
    #1 reset = 1'b1;
    #1;
    check("async_rst_busy", 32'(tx_busy[0]), 0);
    check("async_rst_serial", 32'(tx_serial[0]), 1);
    check("async_rst_done", 32'(tx_done[0]), 0);
    flush_model();
    step();
    step();
    #1 reset = 1'b0;
    repeat (3) step();
    want_data[0] = 8'h3C; want_start[0] = 1'b1;
    step();
    c = cyc; want_start[0] = 1'b0;
    first = -1;
    for (int k = 0; k < 60; k++) begin
      step();
      if (tx_done[0] && first < 0) first = cyc - c;
    end
    check("after_rst_latency", first, 41);

    // tx_start held high with two stop bits: back-to-back frames
    want_data[2] = 8'h96;
    first = -1; second = -1; ndone = 0;
    for (int s = 0; s < 150; s++) begin
      want_start[2] = (s < 100);
      step();
      if (tx_done[2]) begin
        ndone++;
        if (first < 0) first = cyc;
        else if (second < 0) second = cyc;
      end
    end
    check("held_done_count", ndone, 3);
    check("held_frame_spacing", second - first, 45);

    // Randomized traffic on all three instances
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < 3; i++) begin
        want_start[i] = ($urandom_range(0, 7) == 0);
        want_data[i]  = 8'($urandom);
      end
      step();
    end
    for (int i = 0; i < 3; i++) want_start[i] = 1'b0;
    repeat (60) step();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("queue_empty%0d", i), exp_q[i].size(), 0);
      check($sformatf("monitor_idle%0d", i), 32'(mon_act[i]), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
